// File: rtl/lm80c_sio_tx_if.sv
// Z80 I/O bus bundle between the CPU glue logic and the LM80C transmit-only SIO channel.
// master = CPU side, slave = the SIO channel.
`timescale 1ns/1ps
interface lm80c_sio_tx_if;
    logic       cs;
    logic       iorq_n;
    logic       wr_n;
    logic       rd_n;
    logic       a0;
    logic [7:0] din;
    logic [7:0] dout;

    modport master (
        output cs, iorq_n, wr_n, rd_n, a0, din,
        input  dout
    );

    modport slave (
        input  cs, iorq_n, wr_n, rd_n, a0, din,
        output dout
    );
endinterface

// File: rtl/lm80c_sio_tx.sv
// LM80C transmit-only serial channel: Z80 I/O writes feed a small FIFO drained as 8N1 frames on txd.
// Define LM80C_SIO_TX_INT_EN to build the TX-done interrupt (pending flag and registered int_n).
`timescale 1ns/1ps
module lm80c_sio_tx #(
    parameter int CLK_DIV = 16,
    parameter int FIFO_AW = 2
) (
    input  logic               sys_clock,
    input  logic               RESET,
    lm80c_sio_tx_if.slave      bus,
    output logic               txd,
    output logic               tx_busy,
    output logic               int_n
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int CW    = FIFO_AW + 1;

    localparam logic [TW-1:0] TIMER_RELOAD = TW'(CLK_DIV - 1);
    localparam logic [CW-1:0] COUNT_FULL   = CW'(DEPTH);
    localparam logic [CW-1:0] COUNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // ------------------------------------------------------------------
    // CPU write decode: one action per I/O cycle, on the rising edge of ws
    // ------------------------------------------------------------------
    logic w_ws;
    logic r_ws_prev;
    logic w_fire;
    logic w_data_wr;
    logic w_ctl_wr;
    logic w_chan_rst;
    logic w_clr_int;
    logic w_txie_wr;

    assign w_ws       = bus.cs & ~bus.iorq_n & ~bus.wr_n;
    assign w_fire     = w_ws & ~r_ws_prev;
    assign w_data_wr  = w_fire & ~bus.a0;
    assign w_ctl_wr   = w_fire &  bus.a0;
    assign w_chan_rst = w_ctl_wr & (bus.din == 8'h18);
    assign w_clr_int  = w_ctl_wr & (bus.din == 8'h28);
    assign w_txie_wr  = w_ctl_wr & (bus.din[7:4] == 4'h0);

    always_ff @(posedge sys_clock) begin
        if (RESET) begin
            r_ws_prev <= 1'b0;
        end else begin
            r_ws_prev <= w_ws;
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               r_ovr;
    logic               r_txie;

    assign w_full  = (r_count == COUNT_FULL);
    assign w_empty = (r_count == '0);
    // A pop on the same edge frees the slot, so a full FIFO still accepts the byte.
    assign w_push  = w_data_wr & (~w_full | w_pop);

    always_ff @(posedge sys_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.din;
        end
    end

    always_ff @(posedge sys_clock) begin
        if (RESET || w_chan_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + COUNT_ONE;
                2'b01:   r_count <= r_count - COUNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge sys_clock) begin
        if (RESET || w_chan_rst) begin
            r_ovr  <= 1'b0;
            r_txie <= 1'b0;
        end else begin
            if (w_data_wr && w_full && !w_pop) begin
                r_ovr <= 1'b1;
            end
            if (w_txie_wr) begin
                r_txie <= bus.din[1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    tx_state_t   r_state;
    tx_state_t   w_state_next;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_next;
    logic [2:0]  r_bit;
    logic [2:0]  w_bit_next;
    logic        r_txd;
    logic        w_txd_next;
    logic [7:0]  r_shift;
    logic        w_shift_en;
    logic        w_frame_done;
    logic        w_bit_done;

    assign w_bit_done = (r_timer == '0);

    always_ff @(posedge sys_clock) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_timer <= TIMER_RELOAD;
            r_bit   <= '0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
            r_bit   <= w_bit_next;
            r_txd   <= w_txd_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_timer_next = w_bit_done ? TIMER_RELOAD : (r_timer - 1'b1);
        w_bit_next   = r_bit;
        w_txd_next   = r_txd;
        w_pop        = 1'b0;
        w_shift_en   = 1'b0;
        w_frame_done = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_timer_next = TIMER_RELOAD;
                w_txd_next   = 1'b1;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_txd_next   = 1'b0;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_done) begin
                    w_txd_next   = r_shift[0];
                    w_bit_next   = 3'd0;
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_done) begin
                    if (r_bit == 3'd7) begin
                        w_txd_next   = 1'b1;
                        w_state_next = ST_STOP;
                    end else begin
                        // The shifter moves on this same edge, so the next bit is shift[1].
                        w_shift_en = 1'b1;
                        w_txd_next = r_shift[1];
                        w_bit_next = r_bit + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (w_bit_done) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_txd_next   = 1'b0;
                        w_state_next = ST_START;
                    end else begin
                        w_frame_done = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_txd_next   = 1'b1;
            end
        endcase

        // Channel reset aborts the frame immediately; no partial stop bit.
        if (w_chan_rst) begin
            w_state_next = ST_IDLE;
            w_timer_next = TIMER_RELOAD;
            w_bit_next   = 3'd0;
            w_txd_next   = 1'b1;
            w_pop        = 1'b0;
            w_shift_en   = 1'b0;
            w_frame_done = 1'b0;
        end
    end

    always_ff @(posedge sys_clock) begin
        if (RESET) begin
            r_shift <= '0;
        end else if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
        end else if (w_shift_en) begin
            r_shift <= {1'b0, r_shift[7:1]};
        end
    end

    // ------------------------------------------------------------------
    // Interrupt
    // ------------------------------------------------------------------
    logic w_unused;
`ifdef LM80C_SIO_TX_INT_EN
    logic r_pending;
    logic r_int_n;

    always_ff @(posedge sys_clock) begin
        if (RESET || w_chan_rst || w_clr_int) begin
            r_pending <= 1'b0;
        end else if (w_frame_done) begin
            r_pending <= 1'b1;
        end
    end

    always_ff @(posedge sys_clock) begin
        if (RESET) begin
            r_int_n <= 1'b1;
        end else begin
            r_int_n <= ~(r_pending & r_txie);
        end
    end

    assign int_n    = r_int_n;
    assign w_unused = bus.rd_n;
`else
    assign int_n    = 1'b1;
    assign w_unused = ^{bus.rd_n, r_txie, w_frame_done, w_clr_int};
`endif

    // ------------------------------------------------------------------
    // Outputs; RR0 layout: {0, overrun, CTS, 00, TX ready, 0, no RX}
    // ------------------------------------------------------------------
    assign txd      = r_txd;
    assign tx_busy  = (r_state != ST_IDLE) | ~w_empty;
    assign bus.dout = bus.a0 ? {1'b0, r_ovr, 1'b1, 2'b00, ~w_full, 1'b0, 1'b0} : 8'h00;

endmodule

// File: tb/tb_lm80c_sio_tx.sv
// Directed bench for lm80c_sio_tx (CLK_DIV=16, FIFO_AW=2): frame timing, FIFO overrun,
// write-strobe edge detection, channel reset and the optional TX interrupt.
`timescale 1ns/1ps
module tb_lm80c_sio_tx;

`ifdef LM80C_SIO_TX_INT_EN
    localparam bit INT_BUILD = 1'b1;
`else
    localparam bit INT_BUILD = 1'b0;
`endif

    logic sys_clock = 1'b0;
    logic reset;
    logic txd;
    logic tx_busy;
    logic int_n;
    int   n_chk = 0;
    int   n_err = 0;

    lm80c_sio_tx_if bus_if ();

    lm80c_sio_tx #(.CLK_DIV(16), .FIFO_AW(2)) dut (
        .sys_clock (sys_clock),
        .RESET     (reset),
        .bus       (bus_if),
        .txd       (txd),
        .tx_busy   (tx_busy),
        .int_n     (int_n)
    );

    always #5 sys_clock = ~sys_clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Called on a negedge; holds the write strobe for 'hold' clocks.
    task automatic io_write(input logic a0, input logic [7:0] d, input int hold);
        bus_if.a0     = a0;
        bus_if.din    = d;
        bus_if.cs     = 1'b1;
        bus_if.iorq_n = 1'b0;
        bus_if.wr_n   = 1'b0;
        repeat (hold) @(negedge sys_clock);
        bus_if.cs     = 1'b0;
        bus_if.iorq_n = 1'b1;
        bus_if.wr_n   = 1'b1;
    endtask

    task automatic read_status(output logic [7:0] v);
        bus_if.a0     = 1'b1;
        bus_if.cs     = 1'b1;
        bus_if.iorq_n = 1'b0;
        bus_if.rd_n   = 1'b0;
        #1;
        v             = bus_if.dout;
        bus_if.cs     = 1'b0;
        bus_if.iorq_n = 1'b1;
        bus_if.rd_n   = 1'b1;
        bus_if.a0     = 1'b0;
    endtask

    task automatic wait_fall(input string tag);
        int n = 0;
        while (txd !== 1'b0 && n < 50) begin
            @(negedge sys_clock);
            n++;
        end
        chk({tag, "_fall"}, {31'd0, txd}, 32'd0);
    endtask

    // Entered on the first negedge of the start bit; returns 160 clocks later.
    task automatic check_frame(input logic [7:0] b, input string tag);
        logic exp_bit;
        for (int k = 0; k < 160; k++) begin
            int bi = k / 16;
            if (bi == 0)      exp_bit = 1'b0;
            else if (bi == 9) exp_bit = 1'b1;
            else              exp_bit = b[bi-1];
            if ((k % 16) == 0 || (k % 16) == 15)
                chk($sformatf("%s_b%0d_%0d", tag, bi, k % 16), {31'd0, txd}, {31'd0, exp_bit});
            if (k == 159)
                chk({tag, "_busy_end"}, {31'd0, tx_busy}, 32'd1);
            @(negedge sys_clock);
        end
    endtask

    logic [7:0] st;
    int         low_seen;

    initial begin
        reset         = 1'b1;
        bus_if.cs     = 1'b0;
        bus_if.iorq_n = 1'b1;
        bus_if.wr_n   = 1'b1;
        bus_if.rd_n   = 1'b1;
        bus_if.a0     = 1'b0;
        bus_if.din    = 8'h00;
        repeat (3) @(negedge sys_clock);
        reset = 1'b0;
        @(negedge sys_clock);

        // 1. reset state
        chk("rst_txd", {31'd0, txd}, 32'd1);
        chk("rst_busy", {31'd0, tx_busy}, 32'd0);
        chk("rst_int_n", {31'd0, int_n}, 32'd1);
        chk("rst_dout_data", {24'd0, bus_if.dout}, 32'h00);
        read_status(st);
        chk("rst_status", {24'd0, st}, 32'h24);
        @(negedge sys_clock);

        // 2. single byte 0x55
        io_write(1'b0, 8'h55, 1);
        wait_fall("t2");
        check_frame(8'h55, "t2");
        chk("t2_busy_after", {31'd0, tx_busy}, 32'd0);
        chk("t2_txd_after", {31'd0, txd}, 32'd1);

        // 3. six writes 4 clocks apart: five frames back to back, sixth dropped
        fork
            begin
                io_write(1'b0, 8'h31, 1); repeat (3) @(negedge sys_clock);
                io_write(1'b0, 8'h42, 1); repeat (3) @(negedge sys_clock);
                io_write(1'b0, 8'h53, 1); repeat (3) @(negedge sys_clock);
                io_write(1'b0, 8'h64, 1); repeat (3) @(negedge sys_clock);
                io_write(1'b0, 8'h75, 1); repeat (3) @(negedge sys_clock);
                io_write(1'b0, 8'h86, 1);
                read_status(st);
                chk("t3_status_full", {24'd0, st}, 32'h60);
            end
            begin
                wait_fall("t3");
                check_frame(8'h31, "t3_f1");
                check_frame(8'h42, "t3_f2");
                check_frame(8'h53, "t3_f3");
                check_frame(8'h64, "t3_f4");
                check_frame(8'h75, "t3_f5");
                chk("t3_busy_after", {31'd0, tx_busy}, 32'd0);
            end
        join
        read_status(st);
        chk("t3_status_ovr", {24'd0, st}, 32'h64);
        @(negedge sys_clock);
        io_write(1'b1, 8'h18, 1);
        read_status(st);
        chk("t3_status_clr", {24'd0, st}, 32'h24);
        @(negedge sys_clock);

        // 4. strobe held for 20 clocks queues one byte only
        fork
            io_write(1'b0, 8'hC3, 20);
            begin
                wait_fall("t4");
                check_frame(8'hC3, "t4");
            end
        join
        chk("t4_busy_after", {31'd0, tx_busy}, 32'd0);
        chk("t4_txd_after", {31'd0, txd}, 32'd1);

        // 5. channel reset during data bit 3 (0xF7 has bit3 low)
        io_write(1'b0, 8'hF7, 1);
        wait_fall("t5");
        io_write(1'b0, 8'h3C, 1);
        repeat (68) @(negedge sys_clock);
        chk("t5_txd_bit3", {31'd0, txd}, 32'd0);
        io_write(1'b1, 8'h18, 1);
        chk("t5_txd_abort", {31'd0, txd}, 32'd1);
        chk("t5_busy_abort", {31'd0, tx_busy}, 32'd0);
        read_status(st);
        chk("t5_status", {24'd0, st}, 32'h24);
        low_seen = 0;
        repeat (40) begin
            @(negedge sys_clock);
            if (txd !== 1'b1) low_seen++;
        end
        chk("t5_stay_idle", low_seen, 0);

        // 6. TX interrupt (constant 1 when the feature is not built)
        io_write(1'b1, 8'h02, 1);
        read_status(st);
        chk("t6_status_txie", {24'd0, st}, 32'h24);
        @(negedge sys_clock);
        io_write(1'b0, 8'hA5, 1);
        wait_fall("t6");
        check_frame(8'hA5, "t6");
        chk("t6_int_n_early", {31'd0, int_n}, 32'd1);
        repeat (2) @(negedge sys_clock);
        chk("t6_int_n_set", {31'd0, int_n}, INT_BUILD ? 32'd0 : 32'd1);
        io_write(1'b1, 8'h28, 1);
        @(negedge sys_clock);
        chk("t6_int_n_clr", {31'd0, int_n}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
